// File: rtl/vip_flow_ctrl_pkg.sv
// Shared types and default control-packet values for the VIP flow-control stages.
package vip_flow_ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } fc_state_t;

    typedef struct packed {
        logic [15:0] width;
        logic [15:0] height;
        logic [3:0]  interlaced;
    } ctrl_fields_t;

    localparam logic [15:0] WIDTH_DEFAULT_C      = 16'd640;
    localparam logic [15:0] HEIGHT_DEFAULT_C     = 16'd480;
    localparam logic [3:0]  INTERLACED_DEFAULT_C = 4'd0;

endpackage

// File: rtl/vip_skid_fifo2.sv
// Two-entry skid FIFO with a registered head entry and occupancy count.
module vip_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] tail;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // With one entry, a simultaneous push/pop replaces the head directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (empty) head <= din;
                    else       tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vip_flow_control_input.sv
// Avalon-ST to read/stall adapter; control fields apply only once buffered pixels drain.
// Optional VIP_FCI_UNDERFLOW_CHECK_EN adds a sticky flag for reads while empty.
module vip_flow_control_input
    import vip_flow_ctrl_pkg::*;
#(
    parameter int          BITS_PER_SYMBOL    = 8,
    parameter int          SYMBOLS_PER_BEAT   = 3,
    parameter logic [15:0] WIDTH_DEFAULT      = WIDTH_DEFAULT_C,
    parameter logic [15:0] HEIGHT_DEFAULT     = HEIGHT_DEFAULT_C,
    parameter logic [3:0]  INTERLACED_DEFAULT = INTERLACED_DEFAULT_C,
    localparam int         DW                 = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic [DW-1:0] din_data,
    input  logic          din_end_of_video,
    output logic          din_ready,
    input  logic [15:0]   decoder_width,
    input  logic [15:0]   decoder_height,
    input  logic [3:0]    decoder_interlaced,
    input  logic          decoder_vip_ctrl_valid,
    output logic [DW-1:0] data_in,
    output logic          end_of_video_in,
    output logic [15:0]   width_in,
    output logic [15:0]   height_in,
    output logic [3:0]    interlaced_in,
    output logic          vip_ctrl_valid_in,
    input  logic          read,
    output logic          stall_in,
    output logic          underflow_sticky
);

    localparam ctrl_fields_t DEFAULTS = '{width: WIDTH_DEFAULT, height: HEIGHT_DEFAULT,
                                          interlaced: INTERLACED_DEFAULT};

    fc_state_t    state;
    ctrl_fields_t shadow;
    ctrl_fields_t applied;
    ctrl_fields_t incoming;
    logic [DW:0]  fifo_head;
    logic [1:0]   fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;

    assign incoming = '{width: decoder_width, height: decoder_height,
                        interlaced: decoder_interlaced};

    assign din_ready = ~fifo_full & (state == IDLE);
    assign stall_in  = fifo_empty;
    assign push      = din_valid & din_ready;
    assign pop       = read & ~stall_in;

    vip_skid_fifo2 #(
        .W(DW + 1)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  ({din_end_of_video, din_data}),
        .head (fifo_head),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign end_of_video_in = fifo_head[DW];
    assign data_in         = fifo_head[DW-1:0];
    assign width_in        = applied.width;
    assign height_in       = applied.height;
    assign interlaced_in   = applied.interlaced;

    // A pulse arriving on the very cycle the pending update drains wins over the older shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            shadow            <= DEFAULTS;
            applied           <= DEFAULTS;
            vip_ctrl_valid_in <= 1'b0;
        end else begin
            vip_ctrl_valid_in <= 1'b0;
            case (state)
                IDLE: begin
                    if (decoder_vip_ctrl_valid) begin
                        shadow <= incoming;
                        state  <= PENDING;
                    end
                end
                PENDING: begin
                    if (fifo_count == 2'd0) begin
                        applied           <= decoder_vip_ctrl_valid ? incoming : shadow;
                        shadow            <= decoder_vip_ctrl_valid ? incoming : shadow;
                        vip_ctrl_valid_in <= 1'b1;
                        state             <= IDLE;
                    end else if (decoder_vip_ctrl_valid) begin
                        shadow <= incoming;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VIP_FCI_UNDERFLOW_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) underflow_sticky <= 1'b0;
        else if (read & stall_in) underflow_sticky <= 1'b1;
    end
`else
    assign underflow_sticky = 1'b0;
`endif

endmodule
